// File: rtl/sram_frame_writer.sv
// sram_frame_writer: producer end of the SRAM frame-buffer write path.
// Turns a start-of-frame framed RGB565 pixel stream into exactly FRAME_PIXELS
// write beats per frame (short frames padded, long frames truncated), then
// pulses gen_fin and waits for the controller's gen_ack rise/fall handshake.
module sram_frame_writer #(
    parameter int          FRAME_PIXELS = 480000,
    parameter logic [15:0] PAD_COLOR    = 16'h0000,
    parameter int          PAD_GAP      = 4,
    parameter int          ACK_TIMEOUT  = 1048575
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_frame_start,
    input  logic        i_pix_valid,
    input  logic [15:0] i_pix_data,
    output logic [15:0] o_wr_data,
    output logic        o_wr_request,
    output logic        o_gen_fin,
    input  logic        i_gen_ack,
    output logic [15:0] o_frame_cnt,
    output logic [15:0] o_drop_cnt,
    output logic        o_err_short,
    output logic        o_err_ack,
    output logic        o_busy
);

    localparam int          TW   = $clog2(ACK_TIMEOUT + 1);
    localparam int          GW   = $clog2(PAD_GAP + 1);
    localparam logic [19:0] LAST = 20'(FRAME_PIXELS - 1);

    typedef enum logic [2:0] {
        S_SYNC, S_FILL, S_PAD, S_FIN, S_ACK_HI, S_ACK_LO
    } state_t;

    state_t          state, state_d;
    logic [19:0]     pix_cnt, pix_d;
    logic [GW-1:0]   gap_cnt, gap_d;
    logic [TW-1:0]   to_cnt, to_d;
    logic            wr_req_d, fin_d, err_short_d, err_ack_d, drop_inc;
    logic [15:0]     wr_data_d, frame_d, drop_d;

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        state_d     = state;
        pix_d       = pix_cnt;
        gap_d       = gap_cnt;
        to_d        = to_cnt;
        wr_req_d    = 1'b0;
        wr_data_d   = o_wr_data;
        fin_d       = 1'b0;
        frame_d     = o_frame_cnt;
        err_short_d = o_err_short;
        err_ack_d   = o_err_ack;
        drop_inc    = 1'b0;
        case (state)
            S_SYNC: begin
                if (i_frame_start) begin
                    state_d = S_FILL;
                    pix_d   = 20'd0;
                    // A pixel coincident with the strobe is pixel 0.
                    if (i_pix_valid) begin
                        wr_req_d  = 1'b1;
                        wr_data_d = i_pix_data;
                        pix_d     = 20'd1;
                        if (LAST == 20'd0) state_d = S_FIN;
                    end
                end else begin
                    drop_inc = i_pix_valid;
                end
            end
            S_FILL: begin
                if (i_frame_start) begin
                    // Early strobe: the old frame is short, pad it out.
                    err_short_d = 1'b1;
                    state_d     = S_PAD;
                    gap_d       = '0;
                    drop_inc    = i_pix_valid;
                end else if (i_pix_valid) begin
                    wr_req_d  = 1'b1;
                    wr_data_d = i_pix_data;
                    pix_d     = pix_cnt + 20'd1;
                    if (pix_cnt == LAST) state_d = S_FIN;
                end
            end
            S_PAD: begin
                drop_inc = i_pix_valid;
                // One pad beat every PAD_GAP cycles keeps the write FIFO safe.
                if (gap_cnt == GW'(PAD_GAP - 1)) begin
                    gap_d     = '0;
                    wr_req_d  = 1'b1;
                    wr_data_d = PAD_COLOR;
                    pix_d     = pix_cnt + 20'd1;
                    if (pix_cnt == LAST) state_d = S_FIN;
                end else begin
                    gap_d = gap_cnt + 1'b1;
                end
            end
            S_FIN: begin
                drop_inc = i_pix_valid;
                // Never raise gen_fin while the controller still shows ack.
                if (!i_gen_ack) begin
                    fin_d   = 1'b1;
                    to_d    = '0;
                    state_d = S_ACK_HI;
                end
            end
            S_ACK_HI: begin
                drop_inc = i_pix_valid;
                if (i_gen_ack) begin
                    state_d = S_ACK_LO;
                end else if (to_cnt == TW'(ACK_TIMEOUT - 1)) begin
                    err_ack_d = 1'b1;
                    state_d   = S_SYNC;
                end else begin
                    to_d = to_cnt + 1'b1;
                end
            end
            S_ACK_LO: begin
                drop_inc = i_pix_valid;
                if (!i_gen_ack) begin
                    frame_d = o_frame_cnt + 16'd1;
                    pix_d   = 20'd0;
                    state_d = S_SYNC;
                end
            end
            default: state_d = S_SYNC;
        endcase
        drop_d = (drop_inc && o_drop_cnt != 16'hFFFF) ? o_drop_cnt + 16'd1 : o_drop_cnt;
    end

    // State, counters and registered outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state        <= S_SYNC;
            pix_cnt      <= 20'd0;
            gap_cnt      <= '0;
            to_cnt       <= '0;
            o_wr_data    <= 16'd0;
            o_wr_request <= 1'b0;
            o_gen_fin    <= 1'b0;
            o_frame_cnt  <= 16'd0;
            o_drop_cnt   <= 16'd0;
            o_err_short  <= 1'b0;
            o_err_ack    <= 1'b0;
            o_busy       <= 1'b0;
        end else begin
            state        <= state_d;
            pix_cnt      <= pix_d;
            gap_cnt      <= gap_d;
            to_cnt       <= to_d;
            o_wr_data    <= wr_data_d;
            o_wr_request <= wr_req_d;
            o_gen_fin    <= fin_d;
            o_frame_cnt  <= frame_d;
            o_drop_cnt   <= drop_d;
            o_err_short  <= err_short_d;
            o_err_ack    <= err_ack_d;
            o_busy       <= (state_d != S_SYNC);
        end
    end

endmodule
